// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - code parameters and expected-symbol function shared by encoder and decoder
package viterbi_pkg;

   localparam int K        = 3;
   localparam int M        = K - 1;
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;
   localparam int MAX_SYMS = 32;
   localparam int MAX_DATA = MAX_SYMS - M;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic {
      S_DATA,
      S_TAIL
   } enc_state_t;

   function automatic logic [1:0] exp_sym(input logic [M-1:0] st, input logic b);
      logic [K-1:0] r;
      r = {st, b};
      return {^(r & G0), ^(r & G1)};
   endfunction

endpackage

// File: rtl/conv_encoder_tx_if.sv
// rtl/conv_encoder_tx_if.sv - data-bit input stream and coded-symbol output stream
interface conv_encoder_tx_if;

   logic       in_valid;
   logic       in_bit;
   logic       in_last;
   logic       in_ready;
   logic       sym_valid;
   logic [1:0] sym;
   logic       sym_last;
   logic       sym_ready;

   modport slave (
      input  in_valid, in_bit, in_last, sym_ready,
      output in_ready, sym_valid, sym, sym_last
   );

   modport master (
      output in_valid, in_bit, in_last, sym_ready,
      input  in_ready, sym_valid, sym, sym_last
   );

endinterface

// File: rtl/conv_encoder_tx_lfsr16_err.sv
// rtl/conv_encoder_tx_lfsr16_err.sv - Galois LFSR bit-flip injector with saturating flip counter
module lfsr16_err
   import viterbi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_adv,
   input  logic [3:0] i_err_rate,
   output logic [1:0] o_flip,
   output logic [7:0] o_err_cnt
);

   logic [15:0] r_lfsr;
   logic [7:0]  r_err_cnt;
   logic [1:0]  w_flip;
   logic [8:0]  w_sum;
   logic [15:0] w_lfsr_next;

   // flip decision uses the value before this symbol's advance
   assign w_flip      = {r_lfsr[3:0] < i_err_rate, r_lfsr[7:4] < i_err_rate};
   assign w_sum       = {1'b0, r_err_cnt} + {8'd0, w_flip[1]} + {8'd0, w_flip[0]};
   assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr    <= LFSR_SEED;
         r_err_cnt <= 8'd0;
      end else if (i_adv) begin
         r_lfsr    <= w_lfsr_next;
         r_err_cnt <= w_sum[8] ? 8'hFF : w_sum[7:0];
      end
   end

   assign o_flip    = w_flip;
   assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/conv_encoder_tx.sv
// rtl/conv_encoder_tx.sv - rate-1/2 K=3 convolutional encoder with zero-tail framing and error injection
module conv_encoder_tx
   import viterbi_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   conv_encoder_tx_if.slave   bus,
   input  logic [3:0]         err_rate,
   output logic [7:0]         err_cnt
);

   localparam int DW = $clog2(MAX_DATA);
   localparam int TW = (M > 1) ? $clog2(M) : 1;

   enc_state_t    r_state;
   logic [M-1:0]  r_st;
   logic [DW-1:0] r_dcnt;
   logic [TW-1:0] r_tcnt;
   logic          r_sym_valid;
   logic [1:0]    r_sym;
   logic          r_sym_last;

   logic       w_free;
   logic       w_accept;
   logic       w_tail_load;
   logic       w_load;
   logic       w_b;
   logic [1:0] w_code;
   logic [1:0] w_flip;
   logic       w_last_data;
   logic       w_last_tail;

   assign w_free        = !r_sym_valid || bus.sym_ready;
   assign bus.in_ready  = !rst && (r_state == S_DATA) && w_free;
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign w_tail_load   = !rst && (r_state == S_TAIL) && w_free;
   assign w_load        = w_accept || w_tail_load;
   assign w_b           = (r_state == S_DATA) && bus.in_bit;
   assign w_code        = exp_sym(r_st, w_b);
   assign w_last_data   = bus.in_last || (r_dcnt == DW'(MAX_DATA - 1));
   assign w_last_tail   = (r_tcnt == TW'(M - 1));

   lfsr16_err u_err (
      .clk        (clk),
      .rst        (rst),
      .i_adv      (w_load),
      .i_err_rate (err_rate),
      .o_flip     (w_flip),
      .o_err_cnt  (err_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_DATA;
         r_st        <= '0;
         r_dcnt      <= '0;
         r_tcnt      <= '0;
         r_sym_valid <= 1'b0;
         r_sym       <= 2'b00;
         r_sym_last  <= 1'b0;
      end else if (w_load) begin
         r_sym_valid <= 1'b1;
         r_sym       <= w_code ^ w_flip;
         r_st        <= {r_st[M-2:0], w_b};
         if (r_state == S_DATA) begin
            r_sym_last <= 1'b0;
            r_dcnt     <= r_dcnt + DW'(1);
            if (w_last_data)
               r_state <= S_TAIL;
         end else if (w_last_tail) begin
            // trellis is back in state 0; next frame starts clean
            r_sym_last <= 1'b1;
            r_tcnt     <= '0;
            r_dcnt     <= '0;
            r_st       <= '0;
            r_state    <= S_DATA;
         end else begin
            r_sym_last <= 1'b0;
            r_tcnt     <= r_tcnt + TW'(1);
         end
      end else if (bus.sym_ready) begin
         r_sym_valid <= 1'b0;
      end
   end

   assign bus.sym_valid = r_sym_valid;
   assign bus.sym       = r_sym;
   assign bus.sym_last  = r_sym_last;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb/tb_conv_encoder_tx.sv - directed self-checking bench for conv_encoder_tx
module tb_conv_encoder_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] err_rate = 4'd0;
   logic [7:0] err_cnt;

   conv_encoder_tx_if bus();

   conv_encoder_tx dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .err_rate (err_rate),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   bit         toggle = 0;
   bit         acc = 0;
   bit         prev_stall = 0;
   logic [1:0] prev_sym;
   logic       prev_last;
   logic [1:0] tx_q[$];
   logic [2:0] got_q[$];
   logic [2:0] exp_q[$];
   int         got_cyc[$];
   int         acc_cyc[$];
   logic [15:0] m_lfsr;
   int          m_flips;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      acc = 0;
      if (!rst) begin
         acc = bus.in_valid && bus.in_ready;
         if (acc) acc_cyc.push_back(cyc);
         if (prev_stall) begin
            check("hold_sym", 32'(bus.sym), 32'(prev_sym));
            check("hold_last", 32'(bus.sym_last), 32'(prev_last));
         end
         if (bus.sym_valid && !bus.sym_ready)
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         prev_stall = bus.sym_valid && !bus.sym_ready;
         prev_sym   = bus.sym;
         prev_last  = bus.sym_last;
         if (bus.sym_valid && bus.sym_ready) begin
            got_q.push_back({bus.sym_last, bus.sym});
            got_cyc.push_back(cyc);
         end
      end else begin
         prev_stall = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (toggle) bus.sym_ready = !bus.sym_ready;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_bit = 1'b0;
      bus.in_last = 1'b0;
      bus.sym_ready = 1'b1;
      toggle = 0;
      tick();
      tick();
      rst = 1'b0;
      got_q.delete(); got_cyc.delete(); acc_cyc.delete(); tx_q.delete(); exp_q.delete();
      prev_stall = 0;
   endtask

   task automatic run(input int want, input int budget);
      int n = 0;
      while (n < budget && (tx_q.size() > 0 || got_q.size() < want)) begin
         bus.in_valid = (tx_q.size() > 0);
         if (tx_q.size() > 0) {bus.in_last, bus.in_bit} = tx_q[0];
         else {bus.in_last, bus.in_bit} = 2'b00;
         tick();
         if (acc) void'(tx_q.pop_front());
         n++;
      end
      bus.in_valid = 1'b0;
      if (n >= budget) begin
         check("timeout_syms", 32'(got_q.size()), 32'(want));
         check("timeout_tx_left", 32'(tx_q.size()), 32'd0);
      end
   endtask

   task automatic queue_bits(input bit bits[$], input bit last_on_end);
      foreach (bits[i]) tx_q.push_back({last_on_end && (i == bits.size() - 1), bits[i]});
   endtask

   // independent reference: sym1 = s1^s0^b, sym0 = s1^b, plus two zero tail symbols
   task automatic model_frame(input bit bits[$]);
      logic [1:0] s = 2'b00;
      for (int i = 0; i < bits.size() + 2; i++) begin
         logic b;
         b = (i < bits.size()) ? bits[i] : 1'b0;
         exp_q.push_back({i == bits.size() + 1, s[1] ^ s[0] ^ b, s[1] ^ b});
         s = {s[0], b};
      end
   endtask

   task automatic expect_syms(input string tag);
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   function automatic logic [15:0] next_lfsr(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   // zero data encodes to 00, so the emitted symbol is exactly the flip mask
   task automatic model_zero_syms(input int n, input int frame_len);
      for (int i = 0; i < n; i++) begin
         logic [1:0] m;
         m = {m_lfsr[3:0] < 4'd15, m_lfsr[7:4] < 4'd15};
         m_flips += int'(m[1]) + int'(m[0]);
         exp_q.push_back({(i % frame_len) == frame_len - 1, m});
         m_lfsr = next_lfsr(m_lfsr);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      bit f1011[$] = '{1, 0, 1, 1};
      bit f3[$]    = '{1, 0, 1};
      bit f30[$];
      bit f5[$];
      bit z4[$]    = '{0, 0, 0, 0};
      bit z30[$];

      bus.in_valid = 1'b0;
      bus.in_bit = 1'b0;
      bus.in_last = 1'b0;
      bus.sym_ready = 1'b1;

      // reset state
      tick();
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
      check("rst_sym", 32'(bus.sym), 32'd0);
      check("rst_sym_last", 32'(bus.sym_last), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // frame 1,0,1,1 at full rate
      do_reset();
      exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
      queue_bits(f1011, 1);
      run(6, 100);
      expect_syms("basic");
      check("basic_latency", 32'((got_cyc.size() > 0 && acc_cyc.size() > 0) ? got_cyc[0] - acc_cyc[0] : -1), 32'd1);
      check("basic_back_to_back", 32'((got_cyc.size() > 5) ? got_cyc[5] - got_cyc[0] : -1), 32'd5);
      check("basic_err_cnt", 32'(err_cnt), 32'd0);

      // same frame with sym_ready toggling
      do_reset();
      toggle = 1;
      exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
      queue_bits(f1011, 1);
      run(6, 100);
      toggle = 0;
      bus.sym_ready = 1'b1;
      expect_syms("stall");

      // 35 bits without in_last: forced termination at 30 then a new frame
      do_reset();
      for (int i = 0; i < 35; i++) begin
         if (i < 30) f30.push_back(((i * 5 + 1) % 7) < 3);
         else f5.push_back(((i * 5 + 1) % 7) < 3);
      end
      model_frame(f30);
      model_frame(f5);
      queue_bits(f30, 0);
      queue_bits(f5, 1);
      run(39, 200);
      expect_syms("force");
      check("force_tail_gap", 32'((acc_cyc.size() > 30) ? acc_cyc[30] - acc_cyc[29] : -1), 32'd3);
      check("force_first32_contig", 32'((got_cyc.size() > 31) ? got_cyc[31] - got_cyc[0] : -1), 32'd31);

      // full-rate error injection, then saturation
      do_reset();
      err_rate = 4'd15;
      m_lfsr = 16'hACE1;
      m_flips = 0;
      model_zero_syms(6, 6);
      queue_bits(z4, 1);
      run(6, 100);
      expect_syms("inject");
      check("inject_err_cnt", 32'(err_cnt), 32'(m_flips));
      got_q.delete(); exp_q.delete();
      for (int i = 0; i < 30; i++) z30.push_back(1'b0);
      model_zero_syms(320, 32);
      for (int f = 0; f < 10; f++) queue_bits(z30, 0);
      run(320, 1000);
      expect_syms("sat");
      check("sat_err_cnt", 32'(err_cnt), 32'((m_flips > 255) ? 255 : m_flips));
      check("sat_err_cnt_255", 32'(err_cnt), 32'd255);

      // reset mid-frame
      do_reset();
      err_rate = 4'd15;
      queue_bits(f3, 0);
      run(0, 50);
      check("mid_sym_valid_before", 32'(bus.sym_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_sym_valid", 32'(bus.sym_valid), 32'd0);
      check("mid_sym_last", 32'(bus.sym_last), 32'd0);
      check("mid_err_cnt", 32'(err_cnt), 32'd0);
      err_rate = 4'd0;
      got_q.delete(); got_cyc.delete(); acc_cyc.delete();
      exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
      queue_bits(f1011, 1);
      run(6, 100);
      expect_syms("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/conv_encoder_tx.md
# conv_encoder_tx

Rate-1/2 convolutional encoder and frame builder that sits directly upstream of the Viterbi decoder. It accepts a bit stream over a valid/ready handshake and emits 2-bit coded symbols, appending K-1 zero tail symbols per frame so every frame ends in state 0. An LFSR-driven error injector can flip symbol bits at a programmable rate, which exercises the decoder on silicon. Symbol width, code polynomials and frame limit match the decoder exactly.

## Interface
- K, 3, constraint length; encoder memory M = K-1 = 2.
- G0, 3'b111, generator driving sym[1].
- G1, 3'b101, generator driving sym[0].
- MAX_SYMS, 32, maximum symbols per frame, tail included; equals the decoder buffer depth.
- LFSR_SEED, 16'hACE1, error-injector seed; must be nonzero.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  data bit offered.
- in_bit  in  1  data bit.
- in_last  in  1  final data bit of the frame; qualified by in_valid.
- in_ready  out  1  encoder accepts a data bit this cycle.
- sym_valid  out  1  symbol register holds a symbol.
- sym  out  2  coded symbol {G0 parity, G1 parity}, after error injection.
- sym_last  out  1  marks the final tail symbol of the frame.
- sym_ready  in  1  consumer takes the symbol; wired to the decoder's rx_ready.
- err_rate  in  4  per-bit flip threshold; 0 disables injection.
- err_cnt  out  8  saturating count of flipped bits.

## Operation
- Encoder state st[1:0] resets to 0. For input b, form r = {st, b}: sym = {^(r&G0), ^(r&G1)}, and the next state is {st[0], b}.
- FSM states:
  - S_DATA (reset state) accepts data bits.
  - S_TAIL emits K-1 symbols with b=0.
  - From S_TAIL, return to S_DATA after the last tail symbol is loaded.
- Data count dcnt counts up to MAX_SYMS-(K-1) = 30 bits per frame.
- S_DATA moves to S_TAIL when a bit is accepted with in_last=1, or when the 30th bit is accepted (forced termination; in_last is ignored thereafter).
- Tail count tcnt runs 0..K-2. On the last tail symbol, set sym_last=1, then clear dcnt, tcnt and st.
- Error injector:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, advancing once per symbol loaded into the output register.
  - Flip sym[1] if lfsr[3:0] < err_rate; flip sym[0] if lfsr[7:4] < err_rate. Both use the pre-advance LFSR value.
  - err_cnt adds 0, 1 or 2 per symbol and saturates at 255.
  - err_cnt is cleared only by rst.
- The injector never alters sym_last, st, or the counters. Only the emitted bits are corrupted.

## Timing
- A single output register holds the symbol. It can load when free = !sym_valid || sym_ready.
- in_ready = (state==S_DATA) && free, combinational. No combinational path from in_valid to in_ready.
- Data accept: in_valid && in_ready. The symbol appears in the next cycle with sym_valid=1. Latency is 1 cycle.
- Full throughput: one symbol per cycle while sym_ready=1.
- Tail symbols load on consecutive free cycles. in_ready=0 throughout S_TAIL.
- The first bit of the next frame can be accepted in the cycle after the final tail symbol loads (that cycle's state is S_DATA).
- A symbol is consumed when sym_valid && sym_ready. If free and nothing new loads, sym_valid drops next cycle.
- While sym_valid=1 && sym_ready=0, the values of sym and sym_last are held stable.
- Reset values: sym_valid=0, sym=0, sym_last=0, err_cnt=0, lfsr=LFSR_SEED, state=S_DATA, st=0, dcnt=0, tcnt=0.
- in_ready is 0 during the reset cycle and 1 in the first cycle after reset.
- Reset mid-frame discards the partial frame and the pending symbol. No tail is emitted.
- in_last on the 30th bit produces the same result as forced termination: exactly 2 tail symbols.

## Structure
- Shared package viterbi_pkg holds K, M, G0, G1, MAX_SYMS, and function exp_sym(st, b). This is the same function the decoder uses, so encoder and decoder cannot diverge.
- One natural sub-module: lfsr16_err. It contains the LFSR, threshold compare, flip mask and err_cnt, with an advance strobe input.
- FSM, counters and the output register stay in conv_encoder_tx.

## Test plan
- Bits 1,0,1,1 (last on 4th), err_rate=0, sym_ready=1: symbols 11,10,00,01,01,11 on consecutive cycles; sym_last only on 6th; err_cnt=0.
- Same frame with sym_ready toggling 1,0 every cycle: same symbol sequence; sym and sym_last held stable while stalled; in_ready=0 whenever sym_valid && !sym_ready.
- 35 bits streamed, no in_last: 30 data symbols then 2 tail symbols (32 total); sym_last on 32nd; in_ready=0 during tail; 31st bit accepted as first bit of next frame.
- err_rate=15, all-zero frame of 4 bits: every emitted bit whose nibble <15 is flipped; err_cnt matches a reference LFSR model; a long run saturates err_cnt at 255.
- rst asserted after 3 accepted bits with sym_valid=1: next cycle sym_valid=0, sym_last=0, err_cnt=0; new frame 1,0,1,1 reproduces 11,10,00,01,01,11.
- Loopback into decoder, random 30-bit frames, err_rate=0: decoded bits equal input followed by 2 zero tail bits.
